// File: rtl/aidc_seq_pkg.sv
// ---------------------------------------------------------------------------
// aidc_seq_pkg
// Shared types and constants for the AIDC Lite job sequencer.
//   state_t      : sequencer FSM states
//   REG_*        : engine APB register offsets (identical for both engines)
//   STATUS_DONE  : status register value meaning "engine finished"
//   step_addr()  : APB offset for a per-phase step (0..4)
//   step_wdata() : APB write data for a phase/step pair
// ---------------------------------------------------------------------------
package aidc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT,
        SETTLE,
        DONE,
        TIMEOUT
    } state_t;

    localparam logic [31:0] REG_SRC     = 32'h0000_0000;
    localparam logic [31:0] REG_DST     = 32'h0000_0004;
    localparam logic [31:0] REG_LEN     = 32'h0000_0008;
    localparam logic [31:0] REG_CMD     = 32'h0000_000C;
    localparam logic [31:0] REG_STATUS  = 32'h0000_0010;
    localparam logic [31:0] STATUS_DONE = 32'h0000_0001;

    // Steps 0..3 are register writes, step 4 is the status poll.
    localparam logic [2:0] STEP_STATUS = 3'd4;

    function automatic logic [31:0] step_addr(input logic [2:0] step);
        case (step)
            3'd0:    return REG_SRC;
            3'd1:    return REG_DST;
            3'd2:    return REG_LEN;
            3'd3:    return REG_CMD;
            default: return REG_STATUS;
        endcase
    endfunction

    // Phase 0 programs the compressor (src -> tmp), phase 1 the
    // decompressor (tmp -> dst). Reads carry zero write data.
    function automatic logic [31:0] step_wdata(
        input logic        ph,
        input logic [2:0]  step,
        input logic [31:0] src,
        input logic [31:0] tmp,
        input logic [31:0] dst,
        input logic [31:0] clen,
        input logic [31:0] dlen
    );
        case (step)
            3'd0:    return ph ? tmp  : src;
            3'd1:    return ph ? dst  : tmp;
            3'd2:    return ph ? dlen : clen;
            3'd3:    return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/aidc_apb_xfer.sv
// ---------------------------------------------------------------------------
// aidc_apb_xfer
// One APB transfer (SETUP then ACCESS) towards one of two slaves.
//   start/sel/write/addr/wdata : launch a transfer; SETUP appears next cycle.
//                                sel = 0 compressor, 1 decompressor.
//   done/rdata                 : combinational, high in the ACCESS cycle in
//                                which the selected slave's pready is high.
//   psel_comp/psel_decomp/penable/pwrite/paddr/pwdata : APB master outputs.
//   prdata_*/pready_*          : APB slave responses.
// A start in the same cycle as done chains the next transfer with no idle
// cycle. Reset drops psel/penable at once, abandoning any access.
// ---------------------------------------------------------------------------
module aidc_apb_xfer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sel,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        psel_comp,
    output logic        psel_decomp,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata_comp,
    input  logic [31:0] prdata_decomp,
    input  logic        pready_comp,
    input  logic        pready_decomp
);

    // The active psel identifies the target; the other slave's pready is ignored.
    assign done  = penable && (psel_decomp ? pready_decomp : pready_comp);
    assign rdata = psel_decomp ? prdata_decomp : prdata_comp;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_comp   <= 1'b0;
            psel_decomp <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else if (start) begin
            psel_comp   <= !sel;
            psel_decomp <= sel;
            penable     <= 1'b0;
            pwrite      <= write;
            paddr       <= addr;
            pwdata      <= write ? wdata : '0;
        end else if ((psel_comp || psel_decomp) && !penable) begin
            penable     <= 1'b1;
        end else if (done) begin
            psel_comp   <= 1'b0;
            psel_decomp <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end
    end

endmodule

// File: rtl/aidc_job_sequencer.sv
// ---------------------------------------------------------------------------
// aidc_job_sequencer
// Runs one compress-then-decompress round trip through the AIDC Lite engines.
// For each engine: write src, dst, len, start(=1), then poll status every
// POLL_INTERVAL idle cycles until it reads STATUS_DONE (or POLL_MAX reads
// fail -> timeout), then idle SETTLE_CYCLES before moving on.
//   job_valid/job_ready + job_*   : descriptor handshake (accepted in IDLE)
//   job_done/job_err              : one-cycle completion pulse, err = timeout
//   busy/phase                    : job in progress, 0 = compress, 1 = decompress
//   psel_*/penable/pwrite/paddr/pwdata, prdata_*/pready_* : APB master
// ---------------------------------------------------------------------------
module aidc_job_sequencer
    import aidc_seq_pkg::*;
#(
    parameter int POLL_INTERVAL = 100,
    parameter int POLL_MAX      = 10000,
    parameter int SETTLE_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_src_addr,
    input  logic [31:0] job_tmp_addr,
    input  logic [31:0] job_dst_addr,
    input  logic [31:0] job_comp_len,
    input  logic [31:0] job_decomp_len,
    output logic        job_done,
    output logic        job_err,
    output logic        busy,
    output logic        phase,
    output logic        psel_comp,
    output logic        psel_decomp,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata_comp,
    input  logic [31:0] prdata_decomp,
    input  logic        pready_comp,
    input  logic        pready_decomp
);

    localparam int PW = ($clog2(POLL_MAX + 1) > 14) ? $clog2(POLL_MAX + 1) : 14;

    state_t        state;
    logic [2:0]    step;
    logic [PW-1:0] poll_cnt;
    logic [31:0]   cnt;
    logic [31:0]   src_q, tmp_q, dst_q, clen_q, dlen_q;

    logic          xfer_start;
    logic          xfer_done;
    logic [31:0]   xfer_rdata;
    logic          cmd_phase;
    logic [2:0]    cmd_step;
    logic          cmd_write;
    logic [31:0]   cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          wait_end;
    logic          settle_end;

    assign wait_end   = (cnt == 32'(POLL_INTERVAL - 1));
    assign settle_end = (cnt == 32'(SETTLE_CYCLES - 1));

    // The next transfer is launched in the cycle the FSM decides on it, so
    // its SETUP shows up on the bus exactly one cycle later.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        xfer_start = 1'b0;
        cmd_phase  = phase;
        cmd_step   = step;
        case (state)
            IDLE: begin
                if (job_valid && job_ready) begin
                    xfer_start = 1'b1;
                    cmd_phase  = 1'b0;
                    cmd_step   = 3'd0;
                end
            end
            ACCESS: begin
                if (xfer_done && step != STEP_STATUS) begin
                    xfer_start = 1'b1;
                    cmd_step   = step + 3'd1;
                end
            end
            WAIT: begin
                if (wait_end) begin
                    xfer_start = 1'b1;
                    cmd_step   = STEP_STATUS;
                end
            end
            SETTLE: begin
                if (settle_end && !phase) begin
                    xfer_start = 1'b1;
                    cmd_phase  = 1'b1;
                    cmd_step   = 3'd0;
                end
            end
            default: ;
        endcase
        cmd_addr  = step_addr(cmd_step);
        cmd_write = (cmd_step != STEP_STATUS);
        // On acceptance the descriptor is not registered yet; take src live.
        cmd_wdata = (state == IDLE) ? job_src_addr
                  : step_wdata(cmd_phase, cmd_step, src_q, tmp_q, dst_q, clen_q, dlen_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            poll_cnt  <= '0;
            cnt       <= '0;
            src_q     <= '0;
            tmp_q     <= '0;
            dst_q     <= '0;
            clen_q    <= '0;
            dlen_q    <= '0;
            job_ready <= 1'b1;
            job_done  <= 1'b0;
            job_err   <= 1'b0;
            busy      <= 1'b0;
            phase     <= 1'b0;
        end else begin
            job_done <= 1'b0;
            job_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_valid && job_ready) begin
                        src_q     <= job_src_addr;
                        tmp_q     <= job_tmp_addr;
                        dst_q     <= job_dst_addr;
                        clen_q    <= job_comp_len;
                        dlen_q    <= job_decomp_len;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        phase     <= 1'b0;
                        step      <= '0;
                        poll_cnt  <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: state <= ACCESS;
                ACCESS: begin
                    if (xfer_done) begin
                        if (step != STEP_STATUS) begin
                            step  <= step + 3'd1;
                            state <= SETUP;
                        end else if (xfer_rdata == STATUS_DONE) begin
                            cnt   <= '0;
                            state <= SETTLE;
                        end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                            // This was read number POLL_MAX: give up.
                            poll_cnt <= poll_cnt + PW'(1);
                            job_done <= 1'b1;
                            job_err  <= 1'b1;
                            busy     <= 1'b0;
                            state    <= TIMEOUT;
                        end else begin
                            poll_cnt <= poll_cnt + PW'(1);
                            cnt      <= '0;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_end) state <= SETUP;
                    else          cnt   <= cnt + 32'd1;
                end
                SETTLE: begin
                    if (settle_end) begin
                        if (!phase) begin
                            phase    <= 1'b1;
                            step     <= '0;
                            poll_cnt <= '0;
                            state    <= SETUP;
                        end else begin
                            job_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DONE, TIMEOUT: begin
                    job_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    aidc_apb_xfer u_xfer (
        .clk           (clk),
        .rst           (rst),
        .start         (xfer_start),
        .sel           (cmd_phase),
        .write         (cmd_write),
        .addr          (cmd_addr),
        .wdata         (cmd_wdata),
        .done          (xfer_done),
        .rdata         (xfer_rdata),
        .psel_comp     (psel_comp),
        .psel_decomp   (psel_decomp),
        .penable       (penable),
        .pwrite        (pwrite),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .prdata_comp   (prdata_comp),
        .prdata_decomp (prdata_decomp),
        .pready_comp   (pready_comp),
        .pready_decomp (pready_decomp)
    );

endmodule
